// File: rtl/rv32m_div_ctrl_if.sv
// Request, response and divider-core signals of rv32m_div_ctrl.
// The slave modport is the controller's view; master is the execute stage plus core.
interface rv32m_div_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            core_start;
    logic [XLEN-1:0] core_numerator;
    logic [XLEN-1:0] core_denominator;
    logic            core_done;
    logic [XLEN-1:0] core_quotient;
    logic [XLEN-1:0] core_remainder;

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, resp_ready,
               core_done, core_quotient, core_remainder,
        output req_ready, resp_valid, resp_data,
               core_start, core_numerator, core_denominator
    );

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, resp_ready,
               core_done, core_quotient, core_remainder,
        input  req_ready, resp_valid, resp_data,
               core_start, core_numerator, core_denominator
    );
endinterface

// File: rtl/rv32m_div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU operand and result stage around an unsigned divider core.
// Optional DIV_REM_FUSE_EN keeps the last core result so a matching DIV/REM pair skips the core.
module rv32m_div_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    rv32m_div_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, PREP, WAIT, FIX, RESP} state_t;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_nxt;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1, rs2;
    logic [XLEN-1:0] quo_raw, rem_raw;
    logic [XLEN-1:0] num_q, den_q, resp_data_q;

    logic            is_signed, neg_a, neg_b;
    logic            div_zero, overflow, special;
    logic [XLEN-1:0] spec_data, fix_q, fix_r, fix_data;
    logic            hit;
    logic [XLEN-1:0] hit_data;

    logic            acc_signed;
    logic [XLEN-1:0] mag_a, mag_b;

    // Magnitudes are formed from the incoming operands so they are already
    // stable on the core ports in the cycle core_start is raised.
    always_comb begin
        acc_signed = ~bus.req_op[0];
        mag_a = (acc_signed && bus.req_rs1[XLEN-1]) ? -bus.req_rs1 : bus.req_rs1;
        mag_b = (acc_signed && bus.req_rs2[XLEN-1]) ? -bus.req_rs2 : bus.req_rs2;
    end

    always_comb begin
        is_signed = ~op[0];
        neg_a     = is_signed & rs1[XLEN-1];
        neg_b     = is_signed & rs2[XLEN-1];
        div_zero  = (rs2 == '0);
        overflow  = is_signed && (rs1 == MIN_INT) && (rs2 == '1);
        special   = div_zero | overflow;
        if (div_zero)
            spec_data = op[1] ? rs1 : '1;
        else
            spec_data = op[1] ? '0 : MIN_INT;
        fix_q    = (neg_a ^ neg_b) ? -quo_raw : quo_raw;
        fix_r    = neg_a ? -rem_raw : rem_raw;
        fix_data = op[1] ? fix_r : fix_q;
    end

`ifdef DIV_REM_FUSE_EN
    logic            fuse_valid, fuse_signed;
    logic [XLEN-1:0] fuse_rs1, fuse_rs2, fuse_q, fuse_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fuse_valid  <= 1'b0;
            fuse_signed <= 1'b0;
            fuse_rs1    <= '0;
            fuse_rs2    <= '0;
            fuse_q      <= '0;
            fuse_r      <= '0;
        end else if (state == FIX) begin
            fuse_valid  <= 1'b1;
            fuse_signed <= is_signed;
            fuse_rs1    <= rs1;
            fuse_rs2    <= rs2;
            fuse_q      <= fix_q;
            fuse_r      <= fix_r;
        end
    end

    assign hit      = fuse_valid && (fuse_rs1 == rs1) && (fuse_rs2 == rs2)
                      && (fuse_signed == is_signed);
    assign hit_data = op[1] ? fuse_r : fuse_q;
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.req_valid) state_nxt = PREP;
            PREP: state_nxt = (special || hit) ? RESP : WAIT;
            WAIT: if (bus.core_done) state_nxt = FIX;
            FIX:  state_nxt = RESP;
            RESP: if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == RESP);
        bus.core_start = (state == PREP) && !special && !hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op          <= '0;
            rs1         <= '0;
            rs2         <= '0;
            num_q       <= '0;
            den_q       <= '0;
            quo_raw     <= '0;
            rem_raw     <= '0;
            resp_data_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    op  <= bus.req_op;
                    rs1 <= bus.req_rs1;
                    rs2 <= bus.req_rs2;
                    // Core operands only change for a nonzero divisor.
                    if (bus.req_rs2 != '0) begin
                        num_q <= mag_a;
                        den_q <= mag_b;
                    end
                end
                PREP: begin
                    if (special)
                        resp_data_q <= spec_data;
                    else if (hit)
                        resp_data_q <= hit_data;
                end
                WAIT: if (bus.core_done) begin
                    quo_raw <= bus.core_quotient;
                    rem_raw <= bus.core_remainder;
                end
                FIX: resp_data_q <= fix_data;
                default: ;
            endcase
        end
    end

    assign bus.resp_data        = resp_data_q;
    assign bus.core_numerator   = num_q;
    assign bus.core_denominator = den_q;
endmodule

// File: doc/rv32m_div_ctrl.md
Name: rv32m_div_ctrl

Overview:
- Operand/result stage wrapped around the unsigned radix-2 SRT divider core. It implements the RV32M DIV, DIVU, REM and REMU semantics.
- Accepts requests from the execute stage and applies sign magnitude conversion. Resolves divide-by-zero and signed overflow without invoking the core.
- Drives the core with a start pulse, waits for its done, applies result sign fix-up and returns the result through a valid/ready response port.

Parameters:
- XLEN, 32, operand/result width; the core is instantiated with N=XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- req_rs1  in  XLEN  dividend
- req_rs2  in  XLEN  divisor
- resp_valid  out  1  result present
- resp_ready  in  1  consumer takes result
- resp_data  out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU)
- core_start  out  1  one-cycle start pulse to the divider core
- core_numerator  out  XLEN  unsigned magnitude of dividend
- core_denominator  out  XLEN  unsigned magnitude of divisor, nonzero
- core_done  in  1  core result valid, one-cycle pulse
- core_quotient  in  XLEN  unsigned quotient
- core_remainder  in  XLEN  unsigned remainder

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_data=0; core_start=0; core_numerator=0; core_denominator=0.
- The FSM has five states: IDLE, PREP, WAIT, FIX, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register op, rs1 and rs2, and go to PREP.
  - req_ready=0 in all other states.
- PREP:
  - signed = ~op[0].
  - neg_a = signed & rs1[XLEN-1]; neg_b = signed & rs2[XLEN-1].
  - Magnitudes are two's-complement negation when negative. Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
  - If rs2==0: quotient result = all ones, remainder result = rs1 unmodified. Go to RESP without asserting core_start.
  - Else if signed & rs1==0x80000000 & rs2==0xFFFFFFFF: quotient = 0x80000000, remainder = 0. Go to RESP without asserting core_start.
  - Else: register the magnitudes onto core_numerator/core_denominator, assert core_start for exactly one cycle, and go to WAIT.
- WAIT:
  - Hold the core operands stable.
  - On core_done, capture core_quotient and core_remainder, then go to FIX.
  - core_done in any other state is ignored.
- FIX:
  - Quotient is negated if neg_a XOR neg_b.
  - Remainder is negated if neg_a (sign follows dividend).
  - Select per op[1] (0 = quotient, 1 = remainder) into resp_data, then go to RESP.
  - Special cases select the same way in PREP.
- RESP:
  - resp_valid=1 and resp_data is held stable until resp_ready.
  - On resp_valid & resp_ready, resp_valid drops next cycle and the FSM returns to IDLE.
- Latency, with request accepted in cycle T:
  - Special case: resp_valid in T+2.
  - Core case: core_start in T+1; with core_done in cycle D, resp_valid in D+2.
- Back-to-back throughput: the earliest next accept is the cycle after the response handshake. There is no request/response overlap.
- A response stalled by resp_ready=0 holds indefinitely; no new request is accepted.
- Reset asserted mid-operation immediately returns to IDLE with reset output values. The core shares rst; no stale core_done is expected, and any that arrives is ignored outside WAIT.
- All arithmetic is modulo 2^XLEN; no exceptions are raised (RV32M defines none).

Optional Feature:
- DIV_REM_FUSE_EN
  - Defined: the last core-computed signed-corrected quotient and remainder are kept with rs1, rs2 and signed, plus a valid flag.
  - In PREP, a non-special request whose rs1, rs2 and signedness match a valid entry skips the core and goes straight to RESP, selecting per op. Latency is T+2.
  - The entry is written in FIX and invalidated by reset. Special cases neither hit nor update the entry.
  - Undefined: no storage and no hit path; every non-special request uses the core.

Test Plan:
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> core sees 7/2; resp_data=0xFFFFFFFD (-3). REM on the same operands -> 0xFFFFFFFF (-1).
- DIVU rs1=100, rs2=0 -> no core_start; resp_data=0xFFFFFFFF at T+2. REMU on the same operands -> 100.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> no core_start; resp_data=0x80000000. REM on the same operands -> 0.
- REMU rs1=0x80000000, rs2=3 -> core operands unchanged; resp_data=2. resp_ready held low 5 cycles -> resp_valid and data stable, req_ready=0.
- rst pulsed while in WAIT -> outputs return to reset values. A following DIVU 20/6 completes with 3.
- With DIV_REM_FUSE_EN: DIV 0xFFFFFFEC/3, then REM with the same operands -> second request has no core_start, resp_data=0xFFFFFFFE at T+2. Without the macro -> core_start is issued and the result is identical.
